// File: rtl/alu.sv
// Single-cycle RV32I integer execute unit: computes value, resolved next PC and
// taken flag, and broadcasts them on the result bus one cycle after dispatch.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        alu_en,
    input  logic [6:0]  alu_opcode,
    input  logic [2:0]  alu_funct3,
    input  logic        alu_funct7,
    input  logic [31:0] alu_val1,
    input  logic [31:0] alu_val2,
    input  logic [31:0] alu_imm,
    input  logic [31:0] alu_pc,
    input  logic [3:0]  alu_rob_pos,
    output logic        alu_result,
    output logic [3:0]  alu_result_rob_pos,
    output logic [31:0] alu_result_val,
    output logic        alu_result_jump,
    output logic [31:0] alu_result_pc
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] sra_res;
    logic [31:0] arith;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;
    logic        br_take;

    logic [31:0] calc_val;
    logic [31:0] calc_pc;
    logic        calc_jump;

    logic        result_q, result_d;
    logic [3:0]  rob_pos_q, rob_pos_d;
    logic [31:0] val_q, val_d;
    logic        jump_q, jump_d;
    logic [31:0] pc_q, pc_d;

    assign op2         = (alu_opcode == OPC_OP) ? alu_val2 : alu_imm;
    assign shamt       = op2[4:0];
    // Arithmetic shift kept in its own signed expression so it is not
    // demoted to a logical shift by the surrounding unsigned context.
    assign sra_res     = $signed(alu_val1) >>> shamt;
    assign pc_plus4    = alu_pc + 32'd4;
    assign pc_plus_imm = alu_pc + alu_imm;
    assign jalr_sum    = alu_val1 + alu_imm;

    always_comb begin
        arith = 32'd0;
        case (alu_funct3)
            3'b000: arith = (alu_opcode == OPC_OP && alu_funct7) ? (alu_val1 - op2) : (alu_val1 + op2);
            3'b001: arith = alu_val1 << shamt;
            3'b010: arith = {31'd0, $signed(alu_val1) < $signed(op2)};
            3'b011: arith = {31'd0, alu_val1 < op2};
            3'b100: arith = alu_val1 ^ op2;
            3'b101: arith = alu_funct7 ? sra_res : (alu_val1 >> shamt);
            3'b110: arith = alu_val1 | op2;
            3'b111: arith = alu_val1 & op2;
            default: arith = 32'd0;
        endcase
    end

    always_comb begin
        br_take = 1'b0;
        case (alu_funct3)
            3'b000: br_take = (alu_val1 == alu_val2);
            3'b001: br_take = (alu_val1 != alu_val2);
            3'b100: br_take = ($signed(alu_val1) < $signed(alu_val2));
            3'b101: br_take = ($signed(alu_val1) >= $signed(alu_val2));
            3'b110: br_take = (alu_val1 < alu_val2);
            3'b111: br_take = (alu_val1 >= alu_val2);
            default: br_take = 1'b0;
        endcase
    end

    // Unknown opcodes still produce a broadcast so the ROB entry retires.
    always_comb begin
        calc_val  = 32'd0;
        calc_pc   = pc_plus4;
        calc_jump = 1'b0;
        case (alu_opcode)
            OPC_LUI:    calc_val = alu_imm;
            OPC_AUIPC:  calc_val = pc_plus_imm;
            OPC_JAL: begin
                calc_val  = pc_plus4;
                calc_pc   = pc_plus_imm;
                calc_jump = 1'b1;
            end
            OPC_JALR: begin
                calc_val  = pc_plus4;
                calc_pc   = jalr_sum & ~32'd1;
                calc_jump = 1'b1;
            end
            OPC_BRANCH: begin
                calc_jump = br_take;
                calc_pc   = br_take ? pc_plus_imm : pc_plus4;
            end
            OPC_OPIMM,
            OPC_OP:     calc_val = arith;
            default:    calc_val = 32'd0;
        endcase
    end

    always_comb begin
        result_d  = result_q;
        rob_pos_d = rob_pos_q;
        val_d     = val_q;
        jump_d    = jump_q;
        pc_d      = pc_q;
        if (rdy) begin
            if (rollback) begin
                result_d = 1'b0;
                jump_d   = 1'b0;
            end else if (alu_en) begin
                result_d  = 1'b1;
                rob_pos_d = alu_rob_pos;
                val_d     = calc_val;
                jump_d    = calc_jump;
                pc_d      = calc_pc;
            end else begin
                result_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= 1'b0;
            rob_pos_q <= 4'd0;
            val_q     <= 32'd0;
            jump_q    <= 1'b0;
            pc_q      <= 32'd0;
        end else begin
            result_q  <= result_d;
            rob_pos_q <= rob_pos_d;
            val_q     <= val_d;
            jump_q    <= jump_d;
            pc_q      <= pc_d;
        end
    end

    assign alu_result         = result_q;
    assign alu_result_rob_pos = rob_pos_q;
    assign alu_result_val     = val_q;
    assign alu_result_jump    = jump_q;
    assign alu_result_pc      = pc_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected broadcasts are queued at dispatch and
// compared when the result bus pulses.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        alu_result_jump;
    logic [31:0] alu_result_pc;

    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } stim_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .rollback           (rollback),
        .alu_en             (alu_en),
        .alu_opcode         (alu_opcode),
        .alu_funct3         (alu_funct3),
        .alu_funct7         (alu_funct7),
        .alu_val1           (alu_val1),
        .alu_val2           (alu_val2),
        .alu_imm            (alu_imm),
        .alu_pc             (alu_pc),
        .alu_rob_pos        (alu_rob_pos),
        .alu_result         (alu_result),
        .alu_result_rob_pos (alu_result_rob_pos),
        .alu_result_val     (alu_result_val),
        .alu_result_jump    (alu_result_jump),
        .alu_result_pc      (alu_result_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic stim_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [3:0] rob);
        stim_t s;
        s.op = op; s.f3 = f3; s.f7 = f7; s.v1 = v1; s.v2 = v2;
        s.imm = imm; s.pc = pc; s.rob = rob;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic [3:0] rob, input logic [31:0] val,
                                    input logic jump, input logic [31:0] pc);
        exp_t e;
        e.rob = rob; e.val = val; e.jump = jump; e.pc = pc;
        return e;
    endfunction

    // Independent reference for OP / OP-IMM arithmetic.
    function automatic logic [31:0] model_arith(input bit is_op, input logic [2:0] f3,
                                                input logic f7, input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_s;
        int unsigned sh;
        logic [31:0] r;
        sa = a;
        sb_s = b;
        sh = int'(b[4:0]);
        case (f3)
            3'd0: r = (is_op && f7) ? a + (~b + 32'd1) : a + b;
            3'd1: r = a << sh;
            3'd2: r = (sa < sb_s) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (f7) r = sa >>> sh;
                else    r = a >> sh;
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic exp_t got_now();
        return mk_exp(alu_result_rob_pos, alu_result_val, alu_result_jump, alu_result_pc);
    endfunction

    task automatic drive(input stim_t s);
        alu_en      = 1'b1;
        alu_opcode  = s.op;
        alu_funct3  = s.f3;
        alu_funct7  = s.f7;
        alu_val1    = s.v1;
        alu_val2    = s.v2;
        alu_imm     = s.imm;
        alu_pc      = s.pc;
        alu_rob_pos = s.rob;
    endtask

    task automatic idle();
        alu_en = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t g;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; idle();
        alu_opcode = '0; alu_funct3 = '0; alu_funct7 = 1'b0;
        alu_val1 = '0; alu_val2 = '0; alu_imm = '0; alu_pc = '0; alu_rob_pos = '0;
        #2;
        checks++;
        if ({alu_result, got_now()} !== 70'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0", {alu_result, got_now()});
        end
        $display("reset_state result=%b", alu_result);
        @(negedge clk); rst = 1'b0;
        // ADD in flight, then async reset between edges
        @(negedge clk);
        drive(mk(7'b0110011, 3'd0, 1'b0, 32'd10, 32'd20, 32'd0, 32'h80, 4'd2));
        sb.push_back(mk_exp(4'd2, 32'd30, 1'b0, 32'h84));
        @(posedge clk); #2;
        idle();
        e = sb.pop_front();
        g = got_now();
        checks++;
        if (alu_result !== 1'b1 || g !== e) begin
            errors++;
            $display("FAIL reset_preop: got res=%b %h required res=1 %h", alu_result, g, e);
        end
        $display("pre-reset op rob=%0d val=%h", g.rob, g.val);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({alu_result, got_now()} !== 70'd0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0", {alu_result, got_now()});
        end
        $display("async reset outputs=%h", {alu_result, got_now()});
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_result !== 1'b0) begin
            errors++;
            $display("FAIL reset_nopulse: got %b required 0", alu_result);
        end
    endtask

    task automatic test_arith();
        stim_t ops[$];
        exp_t  exps[$];
        exp_t  e;
        exp_t  g;
        ops.push_back(mk(7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3));
        exps.push_back(mk_exp(4'd3, 32'hFFFFFFFE, 1'b0, 32'h204));
        ops.push_back(mk(7'b0110011, 3'd5, 1'b1, 32'h80000000, 32'h24, 32'd0, 32'h204, 4'd4));
        exps.push_back(mk_exp(4'd4, 32'hF8000000, 1'b0, 32'h208));
        // ADDI must ignore bit 30
        ops.push_back(mk(7'b0010011, 3'd0, 1'b1, 32'd5, 32'd0, 32'd7, 32'h208, 4'd5));
        exps.push_back(mk_exp(4'd5, 32'd12, 1'b0, 32'h20C));
        for (int i = 0; i < 24; i++) begin
            stim_t s;
            bit is_op;
            is_op = $urandom_range(0, 1) == 1;
            s = mk(is_op ? 7'b0110011 : 7'b0010011, 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   {$urandom_range(0, 255), 2'b00}, 4'(i));
            ops.push_back(s);
            exps.push_back(mk_exp(s.rob, model_arith(is_op, s.f3, s.f7, s.v1, is_op ? s.v2 : s.imm),
                                  1'b0, s.pc + 32'd4));
        end
        for (int i = 0; i <= ops.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                g = got_now();
                checks++;
                if (alu_result !== 1'b1 || g !== e) begin
                    errors++;
                    $display("FAIL arith_%0d: got res=%b %h required res=1 %h", i - 1, alu_result, g, e);
                end
                $display("arith op %0d rob=%0d val=%h pc=%h", i - 1, g.rob, g.val, g.pc);
            end
            if (i < ops.size()) begin
                drive(ops[i]);
                sb.push_back(exps[i]);
            end else begin
                idle();
            end
        end
        @(negedge clk);
        checks++;
        if (alu_result !== 1'b0) begin
            errors++;
            $display("FAIL arith_idle: got %b required 0", alu_result);
        end
    endtask

    task automatic test_control();
        stim_t ops[$];
        exp_t  exps[$];
        exp_t  e;
        exp_t  g;
        ops.push_back(mk(7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd5));
        exps.push_back(mk_exp(4'd5, 32'd0, 1'b1, 32'h120));
        ops.push_back(mk(7'b1100011, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd6));
        exps.push_back(mk_exp(4'd6, 32'd0, 1'b0, 32'h104));
        ops.push_back(mk(7'b1100011, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd7));
        exps.push_back(mk_exp(4'd7, 32'd0, 1'b0, 32'h104));
        ops.push_back(mk(7'b1100011, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 4'd8));
        exps.push_back(mk_exp(4'd8, 32'd0, 1'b1, 32'h120));
        ops.push_back(mk(7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'h10, 32'h300, 4'd9));
        exps.push_back(mk_exp(4'd9, 32'd0, 1'b1, 32'h310));
        ops.push_back(mk(7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 32'h10, 32'h300, 4'd10));
        exps.push_back(mk_exp(4'd10, 32'd0, 1'b0, 32'h304));
        ops.push_back(mk(7'b1100111, 3'b000, 1'b0, 32'h1001, 32'd0, 32'h4, 32'h40, 4'd11));
        exps.push_back(mk_exp(4'd11, 32'h44, 1'b1, 32'h1004));
        ops.push_back(mk(7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFFFFF8, 32'h40, 4'd12));
        exps.push_back(mk_exp(4'd12, 32'h44, 1'b1, 32'h38));
        ops.push_back(mk(7'b0110111, 3'b000, 1'b0, 32'd1, 32'd2, 32'h12345000, 32'h500, 4'd13));
        exps.push_back(mk_exp(4'd13, 32'h12345000, 1'b0, 32'h504));
        ops.push_back(mk(7'b0010111, 3'b000, 1'b0, 32'd1, 32'd2, 32'h2000, 32'h1000, 4'd14));
        exps.push_back(mk_exp(4'd14, 32'h3000, 1'b0, 32'h1004));
        ops.push_back(mk(7'b1111111, 3'b000, 1'b0, 32'd3, 32'd4, 32'd5, 32'h600, 4'd15));
        exps.push_back(mk_exp(4'd15, 32'd0, 1'b0, 32'h604));
        ops.push_back(mk(7'b1100111, 3'b000, 1'b0, 32'h2000, 32'd0, 32'hFFFFFFFF, 32'h0, 4'd0));
        exps.push_back(mk_exp(4'd0, 32'h4, 1'b1, 32'h1FFE));
        for (int i = 0; i <= ops.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                g = got_now();
                checks++;
                if (alu_result !== 1'b1 || g !== e) begin
                    errors++;
                    $display("FAIL control_%0d: got res=%b %h required res=1 %h", i - 1, alu_result, g, e);
                end
                $display("control op %0d rob=%0d val=%h jump=%b pc=%h", i - 1, g.rob, g.val, g.jump, g.pc);
            end
            if (i < ops.size()) begin
                drive(ops[i]);
                sb.push_back(exps[i]);
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t g;
        exp_t held;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                g = got_now();
                checks++;
                if (alu_result !== 1'b1 || g !== e) begin
                    errors++;
                    $display("FAIL b2b_%0d: got res=%b %h required res=1 %h", i - 1, alu_result, g, e);
                end
                $display("b2b pulse %0d rob=%0d", i - 1, g.rob);
            end
            if (i < 3) begin
                drive(mk(7'b0010011, 3'd0, 1'b0, 32'd100 * i, 32'd0, 32'd1, 32'h700, 4'(10 + i)));
                sb.push_back(mk_exp(4'(10 + i), 32'd100 * i + 32'd1, 1'b0, 32'h704));
            end
        end
        // Stall: first pulse must hold while rdy is low, second op waits.
        idle();
        @(negedge clk);
        drive(mk(7'b0110011, 3'd4, 1'b0, 32'hF0F0F0F0, 32'hFFFF0000, 32'd0, 32'h800, 4'd13));
        sb.push_back(mk_exp(4'd13, 32'h0F0FF0F0, 1'b0, 32'h804));
        @(negedge clk);
        held = sb.pop_front();
        g = got_now();
        checks++;
        if (alu_result !== 1'b1 || g !== held) begin
            errors++;
            $display("FAIL stall_first: got res=%b %h required res=1 %h", alu_result, g, held);
        end
        rdy = 1'b0;
        drive(mk(7'b0110011, 3'd6, 1'b0, 32'h00FF0000, 32'h000000FF, 32'd0, 32'h804, 4'd14));
        sb.push_back(mk_exp(4'd14, 32'h00FF00FF, 1'b0, 32'h808));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            g = got_now();
            checks++;
            if (alu_result !== 1'b1 || g !== held) begin
                errors++;
                $display("FAIL stall_hold_%0d: got res=%b %h required res=1 %h", k, alu_result, g, held);
            end
            $display("stall cycle %0d result=%b rob=%0d", k, alu_result, g.rob);
        end
        rdy = 1'b1;
        @(negedge clk);
        idle();
        e = sb.pop_front();
        g = got_now();
        checks++;
        if (alu_result !== 1'b1 || g !== e) begin
            errors++;
            $display("FAIL stall_second: got res=%b %h required res=1 %h", alu_result, g, e);
        end
        @(negedge clk);
        checks++;
        if (alu_result !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: got %b required 0", alu_result);
        end
    endtask

    task automatic test_rollback();
        exp_t e;
        exp_t g;
        @(negedge clk);
        drive(mk(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h100, 32'h900, 4'd3));
        sb.push_back(mk_exp(4'd3, 32'h904, 1'b1, 32'hA00));
        @(negedge clk);
        e = sb.pop_front();
        g = got_now();
        checks++;
        if (alu_result !== 1'b1 || g !== e) begin
            errors++;
            $display("FAIL rollback_pre: got res=%b %h required res=1 %h", alu_result, g, e);
        end
        rollback = 1'b1;
        drive(mk(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h40, 32'hB00, 4'd4));
        @(negedge clk);
        rollback = 1'b0;
        idle();
        checks++;
        if (alu_result !== 1'b0 || alu_result_jump !== 1'b0) begin
            errors++;
            $display("FAIL rollback_flush: got res=%b jump=%b required 0 0", alu_result, alu_result_jump);
        end
        $display("rollback result=%b jump=%b", alu_result, alu_result_jump);
        @(negedge clk);
        checks++;
        if (alu_result !== 1'b0) begin
            errors++;
            $display("FAIL rollback_after: got %b required 0", alu_result);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_control();
        test_back_to_back();
        test_rollback();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Single-cycle integer execute unit for the out-of-order RV32I core. It accepts one dispatched instruction per cycle from the reservation station and computes the result. For control-flow instructions it also computes the resolved next PC and taken flag. Everything is registered and broadcast one cycle later on the result bus that the reservation station, load/store buffer and ROB snoop.

## Interface
Parameters: none. The ROB index width is fixed at 4 bits and the data width at 32 bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; when low, the block holds all state
- rollback  in  1  mispredict flush from the ROB
- alu_en  in  1  dispatch valid
- alu_opcode  in  7  instruction opcode
- alu_funct3  in  3  instruction funct3
- alu_funct7  in  1  instruction bit 30 (SUB/SRA/SRAI select)
- alu_val1  in  32  rs1 operand
- alu_val2  in  32  rs2 operand
- alu_imm  in  32  sign-extended immediate
- alu_pc  in  32  instruction PC
- alu_rob_pos  in  4  destination ROB entry
- alu_result  out  1  broadcast valid, one-cycle pulse
- alu_result_rob_pos  out  4  ROB entry being written
- alu_result_val  out  32  value destined for rd
- alu_result_jump  out  1  control transfer taken (JAL, JALR, taken branch)
- alu_result_pc  out  32  resolved next PC for the instruction

## Operation
- No backpressure. The block accepts every `alu_en` pulse, with a sustained throughput of one op per cycle.
- Operation is selected by opcode:
  - LUI (0110111): val = imm.
  - AUIPC (0010111): val = pc + imm.
  - JAL (1101111): val = pc + 4; next = pc + imm; jump = 1.
  - JALR (1100111): val = pc + 4; next = (val1 + imm) & ~1; jump = 1.
  - BRANCH (1100011):
    - Conditions by funct3: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
    - jump = condition; next = condition ? pc + imm : pc + 4; val = 0.
  - OP-IMM (0010011): op2 = imm.
  - OP (0110011): op2 = val2.
- Arithmetic for OP and OP-IMM, by funct3:
  - 000: ADD, or SUB when OP and funct7 = 1. ADDI ignores funct7.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7 = 1.
  - 110: OR.
  - 111: AND.
- For every non-control opcode: jump = 0 and next = pc + 4.
- Width rules:
  - All arithmetic wraps modulo 2^32.
  - Shift amount is `op2[4:0]`.
  - SLT/SLTU produce 0 or 1 zero-extended.
- Unrecognised opcode: broadcast still issued with val = 0, jump = 0, next = pc + 4, so the ROB entry never hangs.
- `alu_result_rob_pos` always equals the `alu_rob_pos` captured with the op.

## Timing
- Reset value: all outputs 0 (`alu_result`, `alu_result_rob_pos`, `alu_result_val`, `alu_result_jump`, `alu_result_pc`).
- Latency:
  - Inputs are sampled on edge N when `rdy`=1, `rollback`=0 and `alu_en`=1.
  - The broadcast is visible during cycle N+1 (the outputs are registered).
- `alu_result` is high for exactly one cycle per accepted op.
  - If `alu_en` is 0 on an enabled edge, `alu_result` goes to 0 on that edge.
  - The data outputs may hold stale values while `alu_result` = 0.
- Back-to-back ops on consecutive edges produce back-to-back pulses with no bubble.
- `rdy` = 0: the edge is ignored and all outputs hold their values. A pending pulse therefore stretches until the next `rdy`=1 edge; consumers gate on `rdy` too.
- `rollback` = 1 on an edge (with `rdy` = 1):
  - `alu_result` and `alu_result_jump` go to 0.
  - Any `alu_en` on that edge is discarded.
  - Rollback takes priority over dispatch.
- Async `rst`: outputs go to their reset values immediately, independent of `clk` and `rdy`. An in-flight op is lost.
- There are no internal multi-cycle states. The only sequential state is the output register.

## Test plan
- Reset mid-stream: dispatch ADD on edge N, assert `rst` asynchronously between edges -> all outputs 0 immediately; no pulse on N+1.
- Arithmetic: OP funct3=000 funct7=1, val1=5, val2=7, rob_pos=3 -> next cycle `alu_result`=1, rob_pos=3, val=0xFFFFFFFE, jump=0, pc = pc+4. Then SRA val1=0x80000000, val2=0x24 -> val=0xF8000000 (shift by 4).
- Branches:
  - BLT pc=0x100, imm=0x20, val1=0xFFFFFFFF, val2=1 -> jump=1, pc=0x120, val=0.
  - Same operands as BLTU -> jump=0, pc=0x104.
- JALR: pc=0x40, val1=0x1001, imm=0x4 -> val=0x44, pc=0x1004, jump=1. Then JAL pc=0x40, imm=-8 -> pc=0x38.
- Back-to-back and stall:
  - Dispatch on 3 consecutive edges -> 3 consecutive pulses with matching rob_pos.
  - Drop `rdy` for 2 cycles after the first -> first pulse held 2 extra cycles; no op lost.
- Rollback: `alu_en`=1 and `rollback`=1 on the same edge while a result is pending -> `alu_result`=0 next cycle; no broadcast for either op.
